// File: rtl/vga_pkg.sv
// vga_pkg: timing types, mode enum and mode table for vga_timing_gen.
// Mode 3 is reserved and carries a copy of the 640x480 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    VGA_640X480  = 2'd0,
    VGA_800X600  = 2'd1,
    VGA_1024X768 = 2'd2,
    VGA_RSVD     = 2'd3
  } vga_mode_t;

  // One axis: active / front porch / sync / back porch, and
  // pos=1 means the sync pulse is driven high.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
    logic        pos;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  localparam vga_timing_t MODE_640 = '{
    '{16'd640, 16'd16, 16'd96, 16'd48, 1'b0},
    '{16'd480, 16'd10, 16'd2, 16'd33, 1'b0}
  };
  localparam vga_timing_t MODE_800 = '{
    '{16'd800, 16'd56, 16'd120, 16'd64, 1'b1},
    '{16'd600, 16'd37, 16'd6, 16'd23, 1'b1}
  };
  localparam vga_timing_t MODE_1024 = '{
    '{16'd1024, 16'd24, 16'd136, 16'd160, 1'b0},
    '{16'd768, 16'd3, 16'd6, 16'd29, 1'b0}
  };

  // Index 3 (MSB slot) down to index 0.
  localparam vga_timing_t [3:0] VGA_MODES = {
    MODE_640, MODE_1024, MODE_800, MODE_640
  };

  function automatic int total(input vga_axis_t a);
    return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (count, wrap, sync and active decode).
// Ports: clk_i, rst_i, step_i, cur_i/nxt_i timings, cnt_o, cnt_d_o,
//        wrap_o, act_d_o, sync_o.
// cur_i governs the wrap point of the value held now; nxt_i decodes the
// value being loaded, so a mode change at a frame wrap takes effect at 0.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned   CW       = 11,
  parameter logic [CW-1:0] RST_CNT  = '0,
  parameter logic          RST_SYNC = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          step_i,
  input  vga_axis_t     cur_i,
  input  vga_axis_t     nxt_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_d_o,
  output logic          wrap_o,
  output logic          act_d_o,
  output logic          sync_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] s_beg, s_end;
  logic          sync_q, sync_d;
  logic          in_sync;
  logic          unused_bits;

  assign wrap_o = cnt_q == CW'(total(cur_i) - 1);

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
  end

  assign s_beg   = CW'(nxt_i.active + nxt_i.fp);
  assign s_end   = CW'(nxt_i.active + nxt_i.fp + nxt_i.sync);
  assign in_sync = (cnt_d >= s_beg) && (cnt_d < s_end);
  assign sync_d  = in_sync ? nxt_i.pos : ~nxt_i.pos;
  assign act_d_o = cnt_d < CW'(nxt_i.active);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= RST_CNT;
      sync_q <= RST_SYNC;
    end else if (step_i) begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_d_o     = cnt_d;
  assign sync_o      = sync_q;
  assign unused_bits = ^{cur_i.pos, nxt_i.bp};

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: multi-mode VGA timing generator, mode switched at frame wrap.
// Ports: Clock, Reset, PixelEnable, ModeSelect -> ActiveMode, H/V sync,
//        H/V counters, DisplayEnable, LineStart, FrameStart.
// Macro VGA_TIMING_LOOKAHEAD_EN adds NextHorizontalCounter,
// NextVerticalCounter and NextDisplayEnable (one-pixel prefetch).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned       COUNT_WIDTH  = 11,
  parameter vga_mode_t         DEFAULT_MODE = VGA_640X480,
  parameter vga_timing_t [3:0] MODES        = VGA_MODES
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   PixelEnable,
  input  logic [1:0]             ModeSelect,
  output logic [1:0]             ActiveMode,
  output logic                   HorizontalSync,
  output logic                   VerticalSync,
  output logic [COUNT_WIDTH-1:0] HorizontalCounter,
  output logic [COUNT_WIDTH-1:0] VerticalCounter,
  output logic                   DisplayEnable,
  output logic                   LineStart,
  output logic                   FrameStart
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [COUNT_WIDTH-1:0] NextHorizontalCounter,
  output logic [COUNT_WIDTH-1:0] NextVerticalCounter,
  output logic                   NextDisplayEnable
`endif
);

  localparam vga_timing_t DEF_T = MODES[DEFAULT_MODE];
  localparam logic [COUNT_WIDTH-1:0] H_RST =
    COUNT_WIDTH'(total(DEF_T.h) - 1);
  localparam logic [COUNT_WIDTH-1:0] V_RST =
    COUNT_WIDTH'(total(DEF_T.v) - 1);

  for (genvar m = 0; m < 4; m++) begin : g_chk
    if (total(MODES[m].h) > (1 << COUNT_WIDTH) ||
        total(MODES[m].v) > (1 << COUNT_WIDTH)) begin : g_err
      $error("vga_timing_gen: mode total exceeds COUNT_WIDTH");
    end
  end

  vga_mode_t              mode_q, mode_d;
  logic                   first_q;
  vga_timing_t            cur_t, nxt_t;
  logic                   h_wrap, v_wrap;
  logic                   h_act_d, v_act_d;
  logic [COUNT_WIDTH-1:0] h_d, v_d;
  logic                   de_q, ls_q, fs_q;

  // The wrap straight out of reset is not a real frame end, so the
  // requested mode is only sampled from the second wrap on.
  assign mode_d = (PixelEnable && h_wrap && v_wrap && !first_q) ?
                  vga_mode_t'(ModeSelect) : mode_q;
  assign cur_t  = MODES[mode_q];
  assign nxt_t  = MODES[mode_d];

  vga_axis_counter #(
    .CW(COUNT_WIDTH), .RST_CNT(H_RST), .RST_SYNC(~DEF_T.h.pos)
  ) u_h (
    .clk_i(Clock), .rst_i(Reset), .step_i(PixelEnable),
    .cur_i(cur_t.h), .nxt_i(nxt_t.h),
    .cnt_o(HorizontalCounter), .cnt_d_o(h_d),
    .wrap_o(h_wrap), .act_d_o(h_act_d), .sync_o(HorizontalSync)
  );

  vga_axis_counter #(
    .CW(COUNT_WIDTH), .RST_CNT(V_RST), .RST_SYNC(~DEF_T.v.pos)
  ) u_v (
    .clk_i(Clock), .rst_i(Reset), .step_i(PixelEnable & h_wrap),
    .cur_i(cur_t.v), .nxt_i(nxt_t.v),
    .cnt_o(VerticalCounter), .cnt_d_o(v_d),
    .wrap_o(v_wrap), .act_d_o(v_act_d), .sync_o(VerticalSync)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mode_q  <= DEFAULT_MODE;
      first_q <= 1'b1;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (PixelEnable) begin
      mode_q  <= mode_d;
      first_q <= 1'b0;
      de_q    <= h_act_d & v_act_d;
      ls_q    <= h_d == '0;
      fs_q    <= (h_d == '0) && (v_d == '0);
    end
  end

  assign ActiveMode    = mode_q;
  assign DisplayEnable = de_q;
  assign LineStart     = ls_q;
  assign FrameStart    = fs_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  // Step the freshly loaded position once more under the mode it runs in.
  // A following frame wrap always lands on (0,0), active in every mode.
  logic [COUNT_WIDTH-1:0] nh_d, nv_d, nh_q, nv_q;
  logic                   nde_d, nde_q;
  logic                   h_last, v_last;

  always_comb begin
    h_last = h_d == COUNT_WIDTH'(total(nxt_t.h) - 1);
    v_last = v_d == COUNT_WIDTH'(total(nxt_t.v) - 1);
    nh_d   = h_last ? '0 : h_d + COUNT_WIDTH'(1);
    nv_d   = v_d;
    if (h_last) nv_d = v_last ? '0 : v_d + COUNT_WIDTH'(1);
    nde_d  = (nh_d < COUNT_WIDTH'(nxt_t.h.active)) &&
             (nv_d < COUNT_WIDTH'(nxt_t.v.active));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nh_q  <= '0;
      nv_q  <= '0;
      nde_q <= 1'b1;
    end else if (PixelEnable) begin
      nh_q  <= nh_d;
      nv_q  <= nv_d;
      nde_q <= nde_d;
    end
  end

  assign NextHorizontalCounter = nh_q;
  assign NextVerticalCounter   = nv_q;
  assign NextDisplayEnable     = nde_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table on the VESA table plus a random run on a
// reduced mode table checked against a linear pixel-index reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CW = 11;

  localparam vga_timing_t T0 = '{
    '{16'd8, 16'd2, 16'd3, 16'd2, 1'b0},
    '{16'd4, 16'd1, 16'd2, 16'd1, 1'b0}
  };
  localparam vga_timing_t T1 = '{
    '{16'd6, 16'd1, 16'd2, 16'd3, 1'b1},
    '{16'd3, 16'd2, 16'd1, 16'd1, 1'b1}
  };
  localparam vga_timing_t T2 = '{
    '{16'd10, 16'd1, 16'd1, 16'd1, 1'b1},
    '{16'd5, 16'd1, 16'd1, 16'd2, 1'b0}
  };
  localparam vga_timing_t [3:0] TINY = {T0, T2, T1, T0};

  typedef struct packed {
    logic [1:0]    m;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hs, vs, de, ls, fs;
  } obs_t;

  typedef struct packed {
    logic [CW-1:0] nh;
    logic [CW-1:0] nv;
    logic          nde;
  } la_t;

  typedef struct packed {
    int adv;
    int h;
    int v;
    logic hs, vs, de, ls, fs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, pe1, rst2, pe2;
  logic [1:0]    sel1, sel2, am1, am2;
  logic          hs1, vs1, de1, ls1, fs1;
  logic          hs2, vs2, de2, ls2, fs2;
  logic [CW-1:0] h1, v1, h2, v2;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [CW-1:0] nh1, nv1, nh2, nv2;
  logic          nde1, nde2;
`endif

  vga_timing_gen #(.COUNT_WIDTH(CW)) dut1 (
    .Clock(clk), .Reset(rst1), .PixelEnable(pe1), .ModeSelect(sel1),
    .ActiveMode(am1), .HorizontalSync(hs1), .VerticalSync(vs1),
    .HorizontalCounter(h1), .VerticalCounter(v1),
    .DisplayEnable(de1), .LineStart(ls1), .FrameStart(fs1)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .NextHorizontalCounter(nh1), .NextVerticalCounter(nv1),
    .NextDisplayEnable(nde1)
`endif
  );

  vga_timing_gen #(
    .COUNT_WIDTH(CW), .DEFAULT_MODE(VGA_800X600), .MODES(TINY)
  ) dut2 (
    .Clock(clk), .Reset(rst2), .PixelEnable(pe2), .ModeSelect(sel2),
    .ActiveMode(am2), .HorizontalSync(hs2), .VerticalSync(vs2),
    .HorizontalCounter(h2), .VerticalCounter(v2),
    .DisplayEnable(de2), .LineStart(ls2), .FrameStart(fs2)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .NextHorizontalCounter(nh2), .NextVerticalCounter(nv2),
    .NextDisplayEnable(nde2)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("m=%0d h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b",
      o.m, o.h, o.v, o.hs, o.vs, o.de, o.ls, o.fs);
  endfunction

  task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %s want %s", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_total++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  function automatic obs_t mk(input int m, input int h, input int v,
                              input logic hs, input logic vs,
                              input logic de, input logic ls,
                              input logic fs);
    obs_t o;
    o.m = 2'(m); o.h = CW'(h); o.v = CW'(v);
    o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic obs_t obs1();
    return '{am1, h1, v1, hs1, vs1, de1, ls1, fs1};
  endfunction

  function automatic obs_t obs2();
    return '{am2, h2, v2, hs2, vs2, de2, ls2, fs2};
  endfunction

  // Reference model: a frame is a linear run of pixel indices p; the
  // position, syncs and enables all follow from p and the mode's table.
  int   mp;
  int   mmode;
  bit   mfirst;

  function automatic vga_timing_t tim(input int m);
    return TINY[(m == 3) ? 0 : m];
  endfunction

  function automatic int frame_len(input int m);
    return total(tim(m).h) * total(tim(m).v);
  endfunction

  function automatic logic pin(input int x, input vga_axis_t a);
    int b;
    b = int'(a.active) + int'(a.fp);
    return (x >= b && x < b + int'(a.sync)) ? a.pos : ~a.pos;
  endfunction

  function automatic obs_t model_at(input int p, input int m);
    vga_timing_t t;
    int ht, h, v;
    t  = tim(m);
    ht = total(t.h);
    h  = p % ht;
    v  = p / ht;
    return mk(m, h, v, pin(h, t.h), pin(v, t.v),
              h < int'(t.h.active) && v < int'(t.v.active),
              h == 0, p == 0);
  endfunction

  task automatic model_reset();
    mmode  = 1;
    mp     = frame_len(1) - 1;
    mfirst = 1'b1;
  endtask

  task automatic model_step(input logic pe, input logic [1:0] sel);
    if (pe) begin
      if (mfirst) begin
        mfirst = 1'b0;
        mp     = 0;
      end else if (mp == frame_len(mmode) - 1) begin
        mp    = 0;
        mmode = int'(sel);
      end else begin
        mp++;
      end
    end
  endtask

  task automatic check2(input string nm);
    chk_obs(nm, obs2(), model_at(mp, mmode));
`ifdef VGA_TIMING_LOOKAHEAD_EN
    begin
      obs_t e;
      la_t  ea, aa;
      e  = model_at((mp + 1) % frame_len(mmode), mmode);
      ea = '{e.h, e.v, e.de};
      aa = '{nh2, nv2, nde2};
      n_total++;
      if (aa !== ea) begin
        n_bad++;
        $display("FAIL %s_next: got h=%0d v=%0d de=%0b want h=%0d v=%0d de=%0b",
          nm, aa.nh, aa.nv, aa.nde, ea.nh, ea.nv, ea.nde);
      end
    end
`endif
  endtask

  vec_t vt[11];

  initial begin
    int   de_n, hsl_n, ls_n, holdbad;
    obs_t snap;

    vt[0]  = '{0,   799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1,   0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[2]  = '{1,   1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{638, 639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1,   640, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{15,  655, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1,   656, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{95,  751, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1,   752, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{47,  799, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1,   0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst1 = 1'b1; pe1 = 1'b1; sel1 = 2'd0;
    rst2 = 1'b1; pe2 = 1'b0; sel2 = 2'd0;
    model_reset();

    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    sel1 = 2'd2;
    #1;
    for (int i = 0; i < 11; i++) begin
      repeat (vt[i].adv) @(negedge clk);
      chk_obs($sformatf("vec[%0d]", i), obs1(),
        mk(0, vt[i].h, vt[i].v, vt[i].hs, vt[i].vs,
           vt[i].de, vt[i].ls, vt[i].fs));
    end

    de_n = 0; hsl_n = 0; ls_n = 0;
    for (int i = 0; i < 800; i++) begin
      de_n  += int'(de1);
      hsl_n += int'(!hs1);
      ls_n  += int'(ls1);
      @(negedge clk);
    end
    chk_int("line_de_count", de_n, 640);
    chk_int("line_hsync_low", hsl_n, 96);
    chk_int("line_ls_count", ls_n, 1);

    holdbad = 0;
    for (int i = 0; i < 200; i++) begin
      pe1  = (i % 2 == 0);
      snap = obs1();
      @(negedge clk);
      if (!pe1 && obs1() !== snap) holdbad++;
    end
    chk_int("pe_alt_hold", holdbad, 0);
    chk_int("pe_alt_h", int'(h1), 100);

    pe1 = 1'b1;
    repeat (200) @(negedge clk);
    chk_int("pre_reset_h", int'(h1), 300);
    #2 rst1 = 1'b1;
    #1 chk_obs("async_reset", obs1(),
         mk(0, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    chk_obs("reset_restart", obs1(),
      mk(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));

    rst2 = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      check2($sformatf("rand[%0d]", i));
      if (i % 1700 == 850) begin
        #2 rst2 = 1'b1;
        model_reset();
        #1 check2($sformatf("rand_rst[%0d]", i));
        @(negedge clk);
        rst2 = 1'b0;
      end else begin
        pe2 = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) sel2 = 2'($urandom_range(0, 3));
        model_step(pe2, sel2);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
